scratchpad_tile_mover: RTL and testbench

//  Tile DMA between the load/store unit and the memory arbiter's scratchpad port.

---
 rtl/caches_pkg.sv | 33 +++
 rtl/scratchpad_tile_mover.sv | 150 +++++++++++++++
 tb/tb_scratchpad_tile_mover.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/caches_pkg.sv
// Shared types and constants for the scratchpad tile mover.
// Row geometry is fixed by the arbiter's four-beat scratchpad load burst.
package caches_pkg;

    localparam int unsigned SPTM_ROWS       = 4;
    localparam int unsigned SPTM_ROW_W      = 64;
    localparam int unsigned SPTM_ROW_STRIDE = 8;
    localparam int unsigned SPTM_NUM_MATS   = 4;
    localparam int unsigned SPTM_MAT_W      = $clog2(SPTM_NUM_MATS);
    localparam int unsigned SPTM_TILE_W     = SPTM_ROWS * SPTM_ROW_W;

    typedef enum logic [1:0] {
        SPTM_IDLE  = 2'd0,
        SPTM_LOAD  = 2'd1,
        SPTM_STORE = 2'd2,
        SPTM_DONE  = 2'd3
    } sptm_state_t;

    typedef struct packed {
        logic                   store;
        logic [31:0]            addr;
        logic [SPTM_MAT_W-1:0]  mat;
        logic [SPTM_TILE_W-1:0] tile;
    } sptm_req_t;

    // Row address wraps modulo 2^32 without any flag.
    function automatic logic [31:0] sptm_row_addr(input logic [31:0] base,
                                                  input logic [1:0]  row,
                                                  input int unsigned stride);
        return base + (32'(row) * 32'(stride));
    endfunction

endpackage

// File: rtl/scratchpad_tile_mover.sv
// Tile DMA between the load/store unit and the arbiter's scratchpad port.
// Optional watchdog abort is enabled by defining SPTM_TIMEOUT_EN.
module scratchpad_tile_mover
    import caches_pkg::*;
#(
    parameter int unsigned ROW_STRIDE = SPTM_ROW_STRIDE
`ifdef SPTM_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 1024
`endif
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_store,
    input  logic [31:0]            req_addr,
    input  logic [SPTM_MAT_W-1:0]  req_mat,
    input  logic [SPTM_TILE_W-1:0] req_tile,
    output logic                   sLoad,
    output logic                   sStore,
    output logic [31:0]            load_addr,
    output logic [31:0]            store_addr,
    output logic [SPTM_ROW_W-1:0]  store_data,
    input  logic                   sLoad_hit,
    input  logic [2:0]             sLoad_row,
    input  logic [SPTM_ROW_W-1:0]  load_data,
    input  logic                   sStore_hit,
    output logic                   wr_en,
    output logic [SPTM_MAT_W-1:0]  wr_mat,
    output logic [1:0]             wr_row,
    output logic [SPTM_ROW_W-1:0]  wr_data,
    output logic                   done,
    output logic                   done_store,
    output logic                   done_err
);

    sptm_state_t r_state;
    sptm_req_t   r_req;
    logic [1:0]  r_row_cnt;
    logic        r_err;

    logic w_in_load;
    logic w_in_store;
    logic w_last_load;
    logic w_wd_expire;

    assign w_in_load   = (r_state == SPTM_LOAD);
    assign w_in_store  = (r_state == SPTM_STORE);
    assign w_last_load = sLoad_hit && (sLoad_row == 3'd3);

`ifdef SPTM_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC);

    logic [WD_W-1:0] r_wd_cnt;
    logic            w_wd_clear;

    assign w_wd_clear  = (r_state == SPTM_IDLE) ||
                         (w_in_load && sLoad_hit) || (w_in_store && sStore_hit);
    assign w_wd_expire = (r_wd_cnt == WD_W'(TIMEOUT_CYC - 1));

    // Watchdog: counts idle cycles while waiting on the arbiter.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_wd_cnt <= '0;
        end else if (w_wd_clear) begin
            r_wd_cnt <= '0;
        end else if (w_in_load || w_in_store) begin
            r_wd_cnt <= r_wd_cnt + WD_W'(1);
        end else begin
            r_wd_cnt <= r_wd_cnt;
        end
    end
`else
    assign w_wd_expire = 1'b0;
`endif

    // Request latch, row sequencing and op state.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state   <= SPTM_IDLE;
            r_req     <= '0;
            r_row_cnt <= 2'd0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                SPTM_IDLE: begin
                    if (req_valid) begin
                        r_req     <= '{store: req_store, addr: req_addr,
                                       mat: req_mat, tile: req_tile};
                        r_row_cnt <= 2'd0;
                        r_err     <= 1'b0;
                        r_state   <= req_store ? SPTM_STORE : SPTM_LOAD;
                    end else begin
                        r_state   <= SPTM_IDLE;
                    end
                end
                SPTM_LOAD: begin
                    if (w_last_load) begin
                        r_state <= SPTM_DONE;
                    end else if (w_wd_expire) begin
                        r_err   <= 1'b1;
                        r_state <= SPTM_DONE;
                    end else begin
                        r_state <= SPTM_LOAD;
                    end
                end
                SPTM_STORE: begin
                    // The next row is presented right after a hit; no idle gap.
                    if (sStore_hit) begin
                        r_row_cnt <= r_row_cnt + 2'd1;
                        r_state   <= (r_row_cnt == 2'd3) ? SPTM_DONE : SPTM_STORE;
                    end else if (w_wd_expire) begin
                        r_err     <= 1'b1;
                        r_state   <= SPTM_DONE;
                    end else begin
                        r_state   <= SPTM_STORE;
                    end
                end
                SPTM_DONE: begin
                    r_state <= SPTM_IDLE;
                end
                default: begin
                    r_state <= SPTM_IDLE;
                end
            endcase
        end
    end

    assign req_ready = (r_state == SPTM_IDLE);

    // sLoad drops in the final-row hit cycle so the arbiter cannot restart the burst.
    assign sLoad     = w_in_load && !w_last_load;
    assign load_addr = w_in_load ? r_req.addr : 32'd0;

    assign sStore     = w_in_store;
    assign store_addr = w_in_store ? sptm_row_addr(r_req.addr, r_row_cnt, ROW_STRIDE) : 32'd0;
    assign store_data = w_in_store ? r_req.tile[{r_row_cnt, 6'd0} +: SPTM_ROW_W]
                                   : {SPTM_ROW_W{1'b0}};

    assign wr_en   = w_in_load && sLoad_hit;
    assign wr_mat  = wr_en ? r_req.mat : {SPTM_MAT_W{1'b0}};
    assign wr_row  = wr_en ? sLoad_row[1:0] : 2'd0;
    assign wr_data = wr_en ? load_data : {SPTM_ROW_W{1'b0}};

    assign done       = (r_state == SPTM_DONE);
    assign done_store = done && r_req.store;
    assign done_err   = done && r_err;

endmodule

// File: tb/tb_scratchpad_tile_mover.sv
// Randomized scoreboard bench for scratchpad_tile_mover with a behavioural arbiter.
module tb_scratchpad_tile_mover;

    logic         CLK = 1'b0;
    logic         nRST;
    logic         req_valid, req_ready, req_store;
    logic [31:0]  req_addr;
    logic [1:0]   req_mat;
    logic [255:0] req_tile;
    logic         sLoad, sStore;
    logic [31:0]  load_addr, store_addr;
    logic [63:0]  store_data;
    logic         sLoad_hit;
    logic [2:0]   sLoad_row;
    logic [63:0]  load_data;
    logic         sStore_hit;
    logic         wr_en;
    logic [1:0]   wr_mat, wr_row;
    logic [63:0]  wr_data;
    logic         done, done_store, done_err;

    always #5 CLK = ~CLK;

    scratchpad_tile_mover dut (
        .CLK(CLK), .nRST(nRST),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_addr(req_addr), .req_mat(req_mat), .req_tile(req_tile),
        .sLoad(sLoad), .sStore(sStore), .load_addr(load_addr),
        .store_addr(store_addr), .store_data(store_data),
        .sLoad_hit(sLoad_hit), .sLoad_row(sLoad_row), .load_data(load_data),
        .sStore_hit(sStore_hit),
        .wr_en(wr_en), .wr_mat(wr_mat), .wr_row(wr_row), .wr_data(wr_data),
        .done(done), .done_store(done_store), .done_err(done_err)
    );

    typedef struct { logic [1:0] mat; logic [1:0] row; logic [63:0] data; } wr_exp_t;
    typedef struct { logic [31:0] addr; logic [63:0] data; } st_exp_t;
    typedef struct { logic store; logic err; } dn_exp_t;

    wr_exp_t wr_q[$];
    st_exp_t st_q[$];
    dn_exp_t dn_q[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cyc = -100;
    logic [1:0]  cur_mat = 2'd0;
    logic [31:0] cur_base = 32'd0;

    // arbiter model controls
    int a_mode = 0, a_wait = 0, a_idx = 0, a_burst = 0;
    int stop_after = -1;
    int hits_given = 0;
    int order[4];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural arbiter: random BUSY delays, load rows 0..2 shuffled then row 3.
    initial begin
        sLoad_hit = 1'b0; sLoad_row = 3'd0; load_data = 64'd0; sStore_hit = 1'b0;
        forever begin
            @(posedge CLK); #1;
            if (a_mode == 1 && !sLoad)  a_mode = 0;
            if (a_mode == 2 && !sStore) a_mode = 0;
            sLoad_hit = 1'b0; sStore_hit = 1'b0; sLoad_row = 3'd0;
            case (a_mode)
                0: begin
                    if (sLoad) begin
                        a_mode = 1; a_wait = $urandom_range(0, 3); a_idx = 0; a_burst = 0;
                        for (int i = 0; i < 4; i++) order[i] = i;
                        for (int i = 2; i > 0; i--) begin
                            int j, t;
                            j = $urandom_range(0, i);
                            t = order[i]; order[i] = order[j]; order[j] = t;
                        end
                    end else if (sStore) begin
                        a_mode = 2; a_wait = $urandom_range(0, 3);
                    end
                end
                1: begin
                    if (a_wait > 0) begin
                        a_wait--;
                    end else if (stop_after < 0 || a_burst < stop_after) begin
                        sLoad_hit = 1'b1;
                        sLoad_row = 3'(order[a_idx]);
                        load_data = {$urandom, $urandom};
                        wr_q.push_back('{cur_mat, 2'(order[a_idx]), load_data});
                        check("load_addr", load_addr, cur_base);
                        a_idx++; a_burst++; hits_given++;
                        a_wait = $urandom_range(0, 2);
                        if (a_idx == 4) a_mode = 0;
                    end
                end
                2: begin
                    if (a_wait > 0) begin
                        a_wait--;
                    end else begin
                        sStore_hit = 1'b1;
                        a_wait = $urandom_range(0, 3);
                    end
                end
                default: a_mode = 0;
            endcase
        end
    end

    // Monitor: pops expectations whenever the DUT presents an output.
    initial begin
        wr_exp_t e;
        st_exp_t s;
        dn_exp_t d;
        forever begin
            @(negedge CLK);
            if (nRST) begin
                if (wr_en) begin
                    if (wr_q.size() == 0) begin
                        check("wr_en_unexpected", wr_en, 1'b0);
                    end else begin
                        e = wr_q.pop_front();
                        check("wr_mat", wr_mat, e.mat);
                        check("wr_row", wr_row, e.row);
                        check("wr_data", wr_data, e.data);
                    end
                end
                if (sLoad_hit && sLoad_row == 3'd3) check("sLoad_low_on_last", sLoad, 1'b0);
                if (sStore) begin
                    if (st_q.size() == 0) begin
                        check("sStore_unexpected", sStore, 1'b0);
                    end else begin
                        s = st_q[0];
                        check("store_addr", store_addr, s.addr);
                        check("store_data", store_data, s.data);
                        if (sStore_hit) void'(st_q.pop_front());
                    end
                end
                if (done) begin
                    if (dn_q.size() == 0) begin
                        check("done_unexpected", done, 1'b0);
                    end else begin
                        d = dn_q.pop_front();
                        check("done_store", done_store, d.store);
                        check("done_err", done_err, d.err);
                        done_cyc = cyc;
                    end
                end
            end
        end
    end

    task automatic issue(input logic st, input logic [31:0] addr, input logic [1:0] mat,
                         input logic [255:0] tile, input logic exp_err);
        bit b2b;
        int n;
        @(posedge CLK); #1;
        b2b = (dn_q.size() > 0);
        req_valid = 1'b1; req_store = st; req_addr = addr; req_mat = mat; req_tile = tile;
        n = 0;
        forever begin
            @(negedge CLK);
            if (req_ready) break;
            n++;
            if (n > 5000) break;
        end
        check("accept_in_time", n <= 5000, 1'b1);
        if (n <= 5000) begin
            if (b2b) check("b2b_accept_gap", 64'(cyc - done_cyc), 64'd1);
            cur_mat = mat;
            cur_base = addr;
            if (st) begin
                for (int r = 0; r < 4; r++)
                    st_q.push_back('{addr + 32'(r * 8), tile[r*64 +: 64]});
            end
            dn_q.push_back('{st, exp_err});
        end
        @(posedge CLK); #1;
        req_valid = 1'b0;
        req_addr = $urandom;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((dn_q.size() != 0 || req_ready !== 1'b1) && n < 5000) begin
            @(negedge CLK);
            n++;
        end
        check("idle_reached", n < 5000, 1'b1);
    endtask

    function automatic logic [255:0] rand_tile();
        logic [255:0] t;
        for (int k = 0; k < 8; k++) t[k*32 +: 32] = $urandom;
        return t;
    endfunction

    // Abort the in-flight load with reset and check the block is idle next cycle.
    task automatic reset_abort();
        @(posedge CLK); #1;
        nRST = 1'b0;
        @(posedge CLK);
        dn_q.delete();
        @(negedge CLK);
        check("rst_sLoad", sLoad, 1'b0);
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_done", done, 1'b0);
        @(posedge CLK); #1;
        nRST = 1'b1;
        stop_after = -1;
    endtask

    initial begin
        int h0, n;
        nRST = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_addr = 32'd0;
        req_mat = 2'd0; req_tile = 256'd0;
        repeat (3) @(posedge CLK);
        #1 nRST = 1'b1;
        @(negedge CLK);
        check("reset_req_ready", req_ready, 1'b1);
        check("reset_sLoad", sLoad, 1'b0);
        check("reset_sStore", sStore, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_wr_en", wr_en, 1'b0);

        issue(1'b0, 32'h0000_1000, 2'd2, 256'd0, 1'b0);
        wait_idle();
        issue(1'b1, 32'h0000_2000, 2'd1, rand_tile(), 1'b0);
        wait_idle();
        issue(1'b1, 32'hFFFF_FFF0, 2'd3, rand_tile(), 1'b0);
        wait_idle();

        // back-to-back: load, store, load with request held across DONE
        issue(1'b0, 32'h0000_3000, 2'd0, 256'd0, 1'b0);
        issue(1'b1, 32'h0000_4000, 2'd1, rand_tile(), 1'b0);
        issue(1'b0, 32'h0000_5000, 2'd3, 256'd0, 1'b0);
        wait_idle();

        // reset after two load hits, then a normal load
        stop_after = 2;
        h0 = hits_given;
        issue(1'b0, 32'h0000_6000, 2'd1, 256'd0, 1'b0);
        n = 0;
        while (hits_given < h0 + 2 && n < 2000) begin @(negedge CLK); n++; end
        check("two_hits_seen", n < 2000, 1'b1);
        reset_abort();
        issue(1'b0, 32'h0000_7000, 2'd2, 256'd0, 1'b0);
        wait_idle();

        // arbiter stalled forever
        stop_after = 0;
`ifdef SPTM_TIMEOUT_EN
        issue(1'b0, 32'h0000_8000, 2'd0, 256'd0, 1'b1);
        wait_idle();
        stop_after = -1;
`else
        issue(1'b0, 32'h0000_8000, 2'd0, 256'd0, 1'b0);
        repeat (1000) @(posedge CLK);
        @(negedge CLK);
        check("stall_sLoad_held", sLoad, 1'b1);
        reset_abort();
`endif

        for (int i = 0; i < 40; i++) begin
            logic st;
            logic [31:0] a;
            st = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE8 + 32'($urandom_range(0, 16)))
                                            : $urandom;
            if ($urandom_range(0, 1) == 0) wait_idle();
            issue(st, a, 2'($urandom_range(0, 3)), rand_tile(), 1'b0);
        end
        wait_idle();
        repeat (4) @(posedge CLK);
        check("wr_q_drained", 64'(wr_q.size()), 64'd0);
        check("st_q_drained", 64'(st_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

endmodule
